// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: round-robin whole-frame arbiter of ARP/UDP/ICMP builders onto the MAC TX byte stream
module net_tx_arbiter #(
  parameter int MAX_LEN    = 1514,
  parameter int GAP_CYCLES = 12
) (
  input  logic       logic_clk,
  input  logic       logic_rst,
  input  logic [7:0] arp_tdata_in,
  input  logic       arp_tvalid_in,
  output logic       arp_tready_out,
  input  logic       arp_tlast_in,
  input  logic [7:0] udp_tdata_in,
  input  logic       udp_tvalid_in,
  output logic       udp_tready_out,
  input  logic       udp_tlast_in,
  input  logic [7:0] icmp_tdata_in,
  input  logic       icmp_tvalid_in,
  output logic       icmp_tready_out,
  input  logic       icmp_tlast_in,
  output logic [7:0] net_tdata_out,
  output logic       net_tvalid_out,
  input  logic       net_tready_in,
  output logic       net_tlast_out,
  output logic [2:0] net_ttype_out,
  output logic       net_terr_out
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;
  state_t state, state_nx, end_st;
  logic [1:0] rr_ptr, grant, c1, c2, pick;
  logic [CNT_W-1:0] beat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0] vld;
  logic [7:0] sel_data;
  logic sel_valid, sel_last, force_last, xfer, rdy;
  assign vld = {icmp_tvalid_in, udp_tvalid_in, arp_tvalid_in};
  // granted-source mux and next round-robin winner (search starts after rr_ptr)
  always_comb begin
    sel_valid = grant == 2'd0 ? arp_tvalid_in : grant == 2'd1 ? udp_tvalid_in : icmp_tvalid_in;
    sel_last  = grant == 2'd0 ? arp_tlast_in  : grant == 2'd1 ? udp_tlast_in  : icmp_tlast_in;
    sel_data  = grant == 2'd0 ? arp_tdata_in  : grant == 2'd1 ? udp_tdata_in  : icmp_tdata_in;
    c1 = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
    c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    pick = vld[c1] ? c1 : vld[c2] ? c2 : rr_ptr;
  end
  // frame FSM next state and stream output muxing
  always_comb begin
    state_nx = state;
    net_tdata_out = '0;
    net_tvalid_out = 1'b0;
    net_tlast_out = 1'b0;
    net_terr_out = 1'b0;
    rdy = 1'b0;
    end_st = GAP_CYCLES == 0 ? IDLE : GAP;
    force_last = state == SEND && sel_valid && !sel_last && beat_cnt == CNT_W'(MAX_LEN - 1);
    xfer = state == SEND && sel_valid && net_tready_in;
    case (state)
      IDLE: if (|vld) state_nx = SEND;
      SEND: begin
        net_tdata_out = sel_data;
        net_tvalid_out = sel_valid;
        net_tlast_out = sel_last | force_last;
        net_terr_out = force_last;
        rdy = net_tready_in;
        if (xfer && sel_last) state_nx = end_st;
        else if (xfer && force_last) state_nx = DRAIN;
      end
      DRAIN: begin
        rdy = 1'b1;
        if (sel_valid && sel_last) state_nx = end_st;
      end
      default: if (gap_cnt == '0) state_nx = IDLE;
    endcase
    net_ttype_out = (state == SEND || state == DRAIN) ? (grant == 2'd0 ? 3'b001 : grant == 2'd1 ? 3'b010 : 3'b100) : 3'b000;
    arp_tready_out = rdy && grant == 2'd0;
    udp_tready_out = rdy && grant == 2'd1;
    icmp_tready_out = rdy && grant == 2'd2;
  end
  // state, grant, beat and gap counters
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state <= IDLE;
      rr_ptr <= 2'd2;
      grant <= 2'd3;
      beat_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |vld) begin
        grant <= pick;
        rr_ptr <= pick;
        beat_cnt <= '0;
      end
      if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
      gap_cnt <= (state_nx == GAP && state != GAP) ? GAP_LOAD : (state == GAP && gap_cnt != '0) ? gap_cnt - GAP_W'(1) : gap_cnt;
    end
  end
endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter: table-driven frame-level checks of the TX arbiter with simple builder models
module tb_net_tx_arbiter;
  localparam int MAX_LEN = 1514;
  localparam int GAP = 12;
  logic logic_clk = 1'b0, logic_rst = 1'b0;
  logic [7:0] arp_tdata_in = '0, udp_tdata_in = '0, icmp_tdata_in = '0, net_tdata_out;
  logic arp_tvalid_in = 1'b0, udp_tvalid_in = 1'b0, icmp_tvalid_in = 1'b0;
  logic arp_tlast_in = 1'b0, udp_tlast_in = 1'b0, icmp_tlast_in = 1'b0;
  logic arp_tready_out, udp_tready_out, icmp_tready_out;
  logic net_tvalid_out, net_tready_in = 1'b1, net_tlast_out, net_terr_out;
  logic [2:0] net_ttype_out;
  int nchk = 0, nerr = 0;
  logic [2:0] l_type[$];
  logic [7:0] l_data[$];
  bit l_last[$];
  bit l_err[$];
  int l_cyc[$];
  int done_cyc[3];
  int viol;
  typedef struct {
    bit rst;
    int a_len, u_len, i_len;
    int a_st, u_st, i_st;
    bit tog;
    int nfr;
    logic [8:0] ord;
  } vec_t;
  vec_t vecs[7];

  always #5 logic_clk = ~logic_clk;

  net_tx_arbiter #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .arp_tdata_in(arp_tdata_in), .arp_tvalid_in(arp_tvalid_in), .arp_tready_out(arp_tready_out), .arp_tlast_in(arp_tlast_in),
    .udp_tdata_in(udp_tdata_in), .udp_tvalid_in(udp_tvalid_in), .udp_tready_out(udp_tready_out), .udp_tlast_in(udp_tlast_in),
    .icmp_tdata_in(icmp_tdata_in), .icmp_tvalid_in(icmp_tvalid_in), .icmp_tready_out(icmp_tready_out), .icmp_tlast_in(icmp_tlast_in),
    .net_tdata_out(net_tdata_out), .net_tvalid_out(net_tvalid_out), .net_tready_in(net_tready_in),
    .net_tlast_out(net_tlast_out), .net_ttype_out(net_ttype_out), .net_terr_out(net_terr_out)
  );

  function automatic logic [7:0] dbyte(input int s, input int p);
    return 8'((s * 80 + p * 7 + 3) % 256);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    arp_tvalid_in = 0; udp_tvalid_in = 0; icmp_tvalid_in = 0;
    arp_tlast_in = 0; udp_tlast_in = 0; icmp_tlast_in = 0;
    arp_tdata_in = 0; udp_tdata_in = 0; icmp_tdata_in = 0;
    net_tready_in = 1;
  endtask

  task automatic do_reset();
    logic_rst = 1;
    clear_inputs();
    repeat (2) @(posedge logic_clk);
    #1 logic_rst = 0;
  endtask

  // builder models: source s presents bytes dbyte(s,0..len-1) from cycle st onward
  task automatic run(input int al, input int ul, input int il, input int ast, input int ust, input int ist,
                     input bit tog, input int rst_cyc);
    int len[3];
    int st[3];
    int pos[3];
    bit v[3];
    bit acc[3];
    logic [2:0] rdy;
    int cyc, idle, quiet_end;
    bit fin;
    len[0] = al; len[1] = ul; len[2] = il;
    st[0] = ast; st[1] = ust; st[2] = ist;
    for (int s = 0; s < 3; s++) begin
      pos[s] = 0;
      done_cyc[s] = -1;
    end
    cyc = 0; idle = 0; quiet_end = -1; viol = 0;
    l_type.delete(); l_data.delete(); l_last.delete(); l_err.delete(); l_cyc.delete();
    while (idle <= 15 && cyc < 3000) begin
      for (int s = 0; s < 3; s++) v[s] = cyc >= st[s] && pos[s] < len[s];
      arp_tvalid_in = v[0]; arp_tdata_in = dbyte(0, pos[0]); arp_tlast_in = v[0] && pos[0] == len[0] - 1;
      udp_tvalid_in = v[1]; udp_tdata_in = dbyte(1, pos[1]); udp_tlast_in = v[1] && pos[1] == len[1] - 1;
      icmp_tvalid_in = v[2]; icmp_tdata_in = dbyte(2, pos[2]); icmp_tlast_in = v[2] && pos[2] == len[2] - 1;
      net_tready_in = !tog || (cyc % 2 == 1);
      logic_rst = rst_cyc >= 0 && cyc == rst_cyc;
      #3;
      rdy = {icmp_tready_out, udp_tready_out, arp_tready_out};
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("rst-mid readies", int'(rdy), 0);
        chk("rst-mid valid/last/err", int'({net_tvalid_out, net_tlast_out, net_terr_out}), 0);
        chk("rst-mid ttype", int'(net_ttype_out), 0);
        chk("rst-mid tdata", int'(net_tdata_out), 0);
      end
      if (net_tvalid_out && (rdy != (net_tready_in ? net_ttype_out : 3'b000) || !$onehot(net_ttype_out))) viol++;
      if (cyc <= quiet_end && (rdy != 0 || net_tvalid_out || net_ttype_out != 0)) viol++;
      if (net_tvalid_out && net_tready_in) begin
        l_type.push_back(net_ttype_out);
        l_data.push_back(net_tdata_out);
        l_last.push_back(net_tlast_out);
        l_err.push_back(net_terr_out);
        l_cyc.push_back(cyc);
      end
      for (int s = 0; s < 3; s++) acc[s] = v[s] && rdy[s];
      @(posedge logic_clk);
      #1;
      for (int s = 0; s < 3; s++)
        if (acc[s]) begin
          if (pos[s] == len[s] - 1) begin
            done_cyc[s] = cyc;
            quiet_end = cyc + GAP + 1;
          end
          pos[s]++;
        end
      if (logic_rst) for (int s = 0; s < 3; s++) pos[s] = len[s];
      fin = 1;
      for (int s = 0; s < 3; s++) if (pos[s] < len[s]) fin = 0;
      idle = fin ? idle + 1 : 0;
      cyc++;
    end
    chk("run completes", int'(idle > 15), 1);
    logic_rst = 0;
    clear_inputs();
  endtask

  // split the output log into frames and compare against the expected grant order
  task automatic analyze(input int vi, input logic [8:0] ord, input int nfr, input int al, input int ul, input int il,
                         input int ast, input int ust, input int ist);
    int fs[$];
    int fl[$];
    int lens[3];
    int sts[3];
    int start, s, elen, bad, k;
    logic [2:0] t;
    lens[0] = al; lens[1] = ul; lens[2] = il;
    sts[0] = ast; sts[1] = ust; sts[2] = ist;
    start = 0;
    for (int i = 0; i < l_data.size(); i++)
      if (l_last[i] || i == l_data.size() - 1) begin
        fs.push_back(start);
        fl.push_back(i - start + 1);
        start = i + 1;
      end
    chk($sformatf("v%0d frame count", vi), fs.size(), nfr);
    for (int f = 0; f < nfr && f < fs.size(); f++) begin
      t = ord[3*f +: 3];
      s = t[0] ? 0 : t[1] ? 1 : 2;
      elen = lens[s] > MAX_LEN ? MAX_LEN : lens[s];
      bad = 0;
      for (int j = 0; j < fl[f]; j++) begin
        k = fs[f] + j;
        if (l_type[k] != t || l_data[k] != dbyte(s, j) || l_err[k] != (lens[s] > MAX_LEN && j == MAX_LEN - 1)) bad++;
      end
      chk($sformatf("v%0d f%0d ttype", vi, f), int'(l_type[fs[f]]), int'(t));
      chk($sformatf("v%0d f%0d length", vi, f), fl[f], elen);
      chk($sformatf("v%0d f%0d bad beats", vi, f), bad, 0);
      if (f == 0) chk($sformatf("v%0d first beat cycle", vi), l_cyc[fs[0]], sts[s] + 1);
      else chk($sformatf("v%0d f%0d spacing", vi, f), l_cyc[fs[f]] - l_cyc[fs[f] - 1], GAP + 2);
    end
    chk($sformatf("v%0d protocol violations", vi), viol, 0);
  endtask

  initial begin
    int nl;
    vecs[0] = '{1'b1, 42, 0, 0, 0, 0, 0, 1'b0, 1, 9'b000_000_001};
    vecs[1] = '{1'b1, 10, 10, 10, 0, 0, 0, 1'b0, 3, 9'b100_010_001};
    vecs[2] = '{1'b0, 10, 0, 10, 0, 0, 0, 1'b0, 2, 9'b000_100_001};
    vecs[3] = '{1'b0, 0, 5, 7, 0, 0, 0, 1'b0, 2, 9'b000_100_010};
    vecs[4] = '{1'b1, 0, 64, 0, 0, 0, 0, 1'b1, 1, 9'b000_000_010};
    vecs[5] = '{1'b1, 0, 4, 1, 0, 1, 0, 1'b0, 2, 9'b000_010_100};
    vecs[6] = '{1'b1, 0, 1600, 0, 0, 0, 0, 1'b0, 1, 9'b000_000_010};
    logic_rst = 1;
    arp_tvalid_in = 1; udp_tvalid_in = 1; icmp_tvalid_in = 1;
    net_tready_in = 1;
    @(posedge logic_clk);
    #3;
    chk("reset readies", int'({icmp_tready_out, udp_tready_out, arp_tready_out}), 0);
    chk("reset valid/last/err", int'({net_tvalid_out, net_tlast_out, net_terr_out}), 0);
    chk("reset ttype", int'(net_ttype_out), 0);
    chk("reset tdata", int'(net_tdata_out), 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      run(vecs[i].a_len, vecs[i].u_len, vecs[i].i_len, vecs[i].a_st, vecs[i].u_st, vecs[i].i_st, vecs[i].tog, -1);
      analyze(i, vecs[i].ord, vecs[i].nfr, vecs[i].a_len, vecs[i].u_len, vecs[i].i_len,
              vecs[i].a_st, vecs[i].u_st, vecs[i].i_st);
    end
    chk("trunc drain end cycle", done_cyc[1], 1600);
    do_reset();
    run(0, 0, 30, 0, 0, 0, 1'b0, 20);
    chk("rst-mid beats sent", l_data.size(), 20);
    nl = 0;
    foreach (l_last[i]) if (l_last[i]) nl++;
    chk("rst-mid tlast count", nl, 0);
    run(5, 0, 5, 0, 0, 0, 1'b0, -1);
    analyze(7, 9'b000_100_001, 2, 5, 0, 5, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
